// File: rtl/hall_pkg.sv
// Shared definitions for the hall tachometer: sector decode, invalid codes, FSM states.
package hall_pkg;

  localparam logic [2:0] HALL_INVALID_LO = 3'b000;
  localparam logic [2:0] HALL_INVALID_HI = 3'b111;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    STALL = 2'd2
  } tach_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
  } sector_t;

  // Gray-style hall sequence mapped to electrical sectors 0..5.
  function automatic sector_t sector_decode(input logic [2:0] code);
    sector_t r;
    r = '{valid: 1'b1, sector: 3'd0};
    case (code)
      3'b001:  r.sector = 3'd0;
      3'b011:  r.sector = 3'd1;
      3'b010:  r.sector = 3'd2;
      3'b110:  r.sector = 3'd3;
      3'b100:  r.sector = 3'd4;
      3'b101:  r.sector = 3'd5;
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Hall input synchronizer and stability filter; accept fires on the clock the
// synced code completes DEBOUNCE_CYCLES stable samples and differs from the last accepted one.
module hall_debounce
  import hall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall,
  output logic [2:0] code,
  output logic       accept
);

  localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

  logic [2:0] sync1, sync2, cand, acc_q;
  logic [7:0] cnt, cnt_nxt;

  always_comb begin
    if (sync2 != cand)  cnt_nxt = 8'd1;
    else if (cnt == DB) cnt_nxt = DB;
    else                cnt_nxt = cnt + 8'd1;
  end

  // Combinational accept so the tracker reacts on the same edge the code is taken.
  assign accept = (cnt_nxt == DB) && (sync2 != acc_q);
  assign code   = accept ? sync2 : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      acc_q <= '0;
    end else begin
      sync1 <= hall;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= cnt_nxt;
      if (accept) acc_q <= sync2;
    end
  end

endmodule

// File: rtl/hall_tachometer.sv
// Hall-bus tachometer: signed step accumulation per snapshot window, direction,
// commutation period, stall detection and skip/invalid-code reporting.
module hall_tachometer
  import hall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int PERIOD_WIDTH    = 20,
  parameter int DELTA_WIDTH     = 12,
  parameter int ERR_WIDTH       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              hall,
  input  logic                    snapshot,
  output logic [DELTA_WIDTH-1:0]  step_delta,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    dir,
  output logic                    stalled,
  output logic                    snap_valid,
  output logic [PERIOD_WIDTH-1:0] period_snap,
  output logic [ERR_WIDTH-1:0]    skip_err,
  output logic                    hall_invalid
);

  localparam logic [PERIOD_WIDTH-1:0] P_ONE = 1;
  localparam logic [DELTA_WIDTH-1:0]  D_ONE = 1;
  localparam logic [ERR_WIDTH-1:0]    E_ONE = 1;

  logic [2:0] acc_code;
  logic       acc_stb;

  hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .hall   (hall),
    .code   (acc_code),
    .accept (acc_stb)
  );

  tach_state_e             state;
  sector_t                 dec;
  logic [2:0]              prev_sector;
  logic [3:0]              diff;
  logic [PERIOD_WIDTH-1:0] period_cnt, period_nxt;
  logic [DELTA_WIDTH-1:0]  acc, acc_sum;
  logic                    new_valid, trans, fwd, rev, stall_hit;

  assign dec       = sector_decode(acc_code);
  assign new_valid = acc_stb && dec.valid;
  assign trans     = new_valid && (state != INIT) && (dec.sector != prev_sector);
  assign diff      = (dec.sector >= prev_sector) ? {1'b0, dec.sector} - {1'b0, prev_sector}
                                                 : {1'b0, dec.sector} + 4'd6 - {1'b0, prev_sector};
  assign fwd       = trans && (diff == 4'd1);
  assign rev       = trans && (diff == 4'd5);
  assign stall_hit = (state == TRACK) && !trans && (period_cnt == '1);

  // Leaving STALL the true interval is unknown, so report it as saturated.
  always_comb begin
    period_nxt = period;
    if (trans)          period_nxt = (state == STALL) ? '1 : period_cnt;
    else if (stall_hit) period_nxt = '1;
  end

  always_comb begin
    acc_sum = acc;
    if (fwd)      acc_sum = acc + D_ONE;
    else if (rev) acc_sum = acc - D_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      prev_sector  <= '0;
      period_cnt   <= '0;
      period       <= '1;
      acc          <= '0;
      step_delta   <= '0;
      dir          <= 1'b0;
      stalled      <= 1'b1;
      snap_valid   <= 1'b0;
      period_snap  <= '0;
      skip_err     <= '0;
      hall_invalid <= 1'b0;
    end else begin
      period     <= period_nxt;
      snap_valid <= snapshot;
      if (snapshot) begin
        step_delta  <= acc_sum;
        period_snap <= period_nxt;
        acc         <= '0;
      end else begin
        acc <= acc_sum;
      end
      if (acc_stb) hall_invalid <= !dec.valid;
      if (fwd)      dir <= 1'b1;
      else if (rev) dir <= 1'b0;
      if (trans && !fwd && !rev && (skip_err != '1)) skip_err <= skip_err + E_ONE;

      if (trans) begin
        prev_sector <= dec.sector;
        period_cnt  <= P_ONE;
        stalled     <= 1'b0;
        state       <= TRACK;
      end else begin
        case (state)
          INIT: if (new_valid) begin
            prev_sector <= dec.sector;
            period_cnt  <= P_ONE;
            state       <= TRACK;
          end
          TRACK: if (stall_hit) begin
            state   <= STALL;
            stalled <= 1'b1;
          end else begin
            period_cnt <= period_cnt + P_ONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/hall_tachometer.md
Name: hall_tachometer

Overview:
- Sits alongside the BLDC driver on the same 3-bit hall bus. Decodes hall transitions into signed commutation steps, direction, commutation period and stall status.
- Its snapshot outputs feed the duty-cycle/velocity control loop, which in turn drives the BLDC driver's duty_cycle input.
- Does not modify or gate the hall signals going to the driver.

Parameters:
- DEBOUNCE_CYCLES, 8, clocks a synced hall code must stay stable before it is accepted (1..255).
- PERIOD_WIDTH, 20, width of the commutation period counter.
- DELTA_WIDTH, 12, width of the signed per-window step accumulator.
- ERR_WIDTH, 8, width of the saturating skip-error counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- hall, input, 3, raw hall sensor lines (pulled up, asynchronous).
- snapshot, input, 1, single-cycle strobe: latch the window outputs and restart the window.
- step_delta, output, DELTA_WIDTH, signed step count over the last completed window.
- period, output, PERIOD_WIDTH, clocks between the last two accepted transitions.
- dir, output, 1, 1 = forward (sector +1), 0 = reverse.
- stalled, output, 1, no accepted transition for 2^PERIOD_WIDTH-1 clocks.
- snap_valid, output, 1, pulses 1 cycle when step_delta and period_snap update.
- period_snap, output, PERIOD_WIDTH, value of period captured at snapshot.
- skip_err, output, ERR_WIDTH, saturating count of non-adjacent sector jumps.
- hall_invalid, output, 1, accepted code is 000 or 111.

Behaviour:
- Reset values:
  - all outputs 0, except stalled=1 and period = all-ones;
  - internal state = INIT.
- Input path:
  - 2-flop synchronizer on hall.
  - Debounce counter reloads on any change of the synced code.
  - Code is accepted when it has been stable for DEBOUNCE_CYCLES clocks.
  - Latency, raw edge to accepted code: 2 + DEBOUNCE_CYCLES clocks.
- Sector decode of the accepted code: 001->0, 011->1, 010->2, 110->3, 100->4, 101->5. Codes 000/111 set hall_invalid=1 and produce no sector.
- State machine:
  - INIT:
    - wait for the first valid accepted code;
    - store it as prev_sector;
    - go to TRACK. No step counted and period untouched in this state.
  - TRACK, on each newly accepted valid sector s != prev_sector:
    - d = (s - prev_sector) mod 6;
    - d = 1: accumulator +1, dir=1;
    - d = 5: accumulator -1, dir=0;
    - d in {2,3,4}: skip_err += 1 (saturates at max), no step, dir unchanged;
    - in all three cases: prev_sector = s, period <= period_cnt, period_cnt <= 1, stalled=0.
  - Invalid codes in TRACK: hall_invalid=1, prev_sector held, no step. hall_invalid clears when the next valid code is accepted.
  - STALL: entered from TRACK when period_cnt reaches all-ones.
    - period forced to all-ones, stalled=1;
    - the next valid transition returns to TRACK and is counted normally, but period is loaded with all-ones (the true interval is unknown).
- period_cnt increments every clock in TRACK and saturates at all-ones.
- Accumulator wraps modulo 2^DELTA_WIDTH (two's complement).
- snapshot, on the cycle it is high:
  - step_delta <= accumulator plus the current cycle's step;
  - period_snap <= period (or the new period if a transition lands the same cycle);
  - accumulator <= 0;
  - snap_valid=1 on the next cycle.
  - A step coinciding with snapshot is counted in the closing window, never lost or double-counted.
- snapshot in INIT: step_delta=0 and snap_valid still pulses.
- Asynchronous reset mid-operation returns everything to the reset values immediately, including the synchronizer flops.

Decomposition:
- Shared package hall_pkg holds:
  - the sector decode function (code -> {valid, sector[2:0]});
  - localparams HALL_INVALID_LO=3'b000 and HALL_INVALID_HI=3'b111;
  - state encodings INIT/TRACK/STALL.
- One natural sub-module: hall_debounce, containing the synchronizer, stability counter and accepted-code/accept-strobe outputs.

Test Plan:
- Forward sequence 001,011,010,110,100,101,001 with each code held 1000 clocks, then snapshot -> step_delta=+6, dir=1, period=1000, period_snap=1000, skip_err=0.
- Reverse sequence 001,101,100,110 held 500 clocks each -> step_delta=-3, dir=0, period=500.
- Glitch of 3 clocks (001->011->001) with DEBOUNCE_CYCLES=8 -> no step, period_cnt keeps counting. Jump 001->110 -> skip_err=1, step_delta unchanged.
- Hold 111 for 10 clocks (> debounce) -> hall_invalid=1, prev_sector held. Then 011 -> hall_invalid=0, +1 step.
- Hold a sector with PERIOD_WIDTH=8 -> stalled=1 after 255 clocks. Next transition -> stalled=0, period=255.
- Transition accepted on the same cycle as snapshot -> counted in the closing step_delta, and the next window starts at 0. Then assert rst_n=0 mid-window -> step_delta=0, stalled=1, state INIT.
